// File: rtl/calc_ctrl_pkg.sv
// Shared definitions for the calculator controller: state encoding, default widths, mode constant.
package calc_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned OP_W_DEF   = 4;
  localparam logic        MODE_UNARY = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_OP = 3'd1,
    ST_LOAD_A  = 3'd2,
    ST_LOAD_B  = 3'd3,
    ST_ISSUE   = 3'd4
  } state_e;

endpackage

// File: rtl/serial_shift_in.sv
// MSB-first serial-to-parallel field register with synchronous clear and shift enable.
module serial_shift_in #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  logic [W-1:0] field_q;

  // Clear wins over shift so a start/abort edge always leaves the field at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      field_q <= '0;
    end else if (clr) begin
      field_q <= '0;
    end else if (en) begin
      field_q <= {field_q[W-2:0], din};
    end
  end

  assign q = field_q;

endmodule

// File: rtl/cmd_operand_loader.sv
// Assembles opcode and one or two operands from serial key bits and issues them to the ALU
// through a valid/ready handshake.
module cmd_operand_loader
  import calc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic              mode,
  input  logic              input_key,
  input  logic              valid_cmd,
  input  logic              alu_ready,
  output logic              load_valid,
  output logic [OP_W-1:0]   opcode,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] OP_LAST   = CNT_W'(OP_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q;
  logic             mode_q, mode_d;
  logic             load_valid_q, load_valid_d;
  logic             busy_q, busy_d;

  logic             start;
  logic             clr;
  logic             en_op, en_a, en_b;
  logic [CNT_W-1:0] last_idx;

  assign start    = active & ~active_q;
  assign last_idx = (state_q == ST_LOAD_OP) ? OP_LAST : DATA_LAST;

  // Next-state, counter and field-control decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    clr     = 1'b0;
    en_op   = 1'b0;
    en_a    = 1'b0;
    en_b    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_OP;
          cnt_d   = '0;
          mode_d  = mode;
          clr     = 1'b1;
        end
      end
      ST_LOAD_OP, ST_LOAD_A, ST_LOAD_B: begin
        if (!active) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          clr     = 1'b1;
        end else if (valid_cmd) begin
          en_op = (state_q == ST_LOAD_OP);
          en_a  = (state_q == ST_LOAD_A);
          en_b  = (state_q == ST_LOAD_B);
          if (cnt_q == last_idx) begin
            cnt_d = '0;
            if (state_q == ST_LOAD_OP) begin
              state_d = ST_LOAD_A;
            end else if (state_q == ST_LOAD_A && mode_q != MODE_UNARY) begin
              state_d = ST_LOAD_B;
            end else begin
              state_d = ST_ISSUE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ISSUE: begin
        if (load_valid_q && alu_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    load_valid_d = (state_d == ST_ISSUE);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      active_q     <= 1'b0;
      mode_q       <= 1'b0;
      load_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_q     <= active;
      mode_q       <= mode_d;
      load_valid_q <= load_valid_d;
      busy_q       <= busy_d;
    end
  end

  serial_shift_in #(.W(OP_W)) u_opcode (
    .clk(clk), .reset(reset), .clr(clr), .en(en_op), .din(input_key), .q(opcode)
  );

  serial_shift_in #(.W(DATA_W)) u_op_a (
    .clk(clk), .reset(reset), .clr(clr), .en(en_a), .din(input_key), .q(op_a)
  );

  serial_shift_in #(.W(DATA_W)) u_op_b (
    .clk(clk), .reset(reset), .clr(clr), .en(en_b), .din(input_key), .q(op_b)
  );

  assign load_valid = load_valid_q;
  assign busy       = busy_q;

endmodule
